tb_sample_checker: RTL and testbench
====================================

TB_SAMPLE_CHECKER -- requirements
Module: tb_sample_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per channel sample (signed two's complement).
REQ-002 SHALL have parameter CHANNELS, default 4, number of parallel channels.
REQ-003 SHALL have parameter DEPTH, default 16, expected-sample FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter TOLERANCE, default 0, max allowed |actual-expected| per channel.
REQ-005 SHALL have parameter NUM_SAMPLES, default 1024, actual samples per test run (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  input  1  one-cycle pulse beginning a run.
REQ-009 SHALL have port exp_valid  input  1  expected vector offered.
REQ-010 SHALL have port exp_ready  output  1  expected vector accepted when high with exp_valid.
REQ-011 SHALL have port exp_data  input  CHANNELS*DATA_WIDTH  expected vector; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port act_valid  input  1  DUT output sample present (no backpressure).
REQ-013 SHALL have port act_data  input  CHANNELS*DATA_WIDTH  DUT output vector, same packing.
REQ-014 SHALL have port done  output  1  run finished.
REQ-015 SHALL have port test_passed  output  1  run finished with no errors.
REQ-016 SHALL have port err_count  output  16  mismatching samples, saturating.
REQ-017 SHALL have port sample_count  output  $clog2(NUM_SAMPLES+1)  compared samples.
REQ-018 SHALL have port err_chan_mask  output  CHANNELS  sticky per-channel mismatch flags.
REQ-019 SHALL have port underflow  output  1  sticky: actual sample arrived with FIFO empty.
REQ-020 SHALL have port leftover  output  1  sticky: FIFO non-empty at end of run.

Function
REQ-021 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the edge sample_count becomes NUM_SAMPLES; DONE->RUN on start; start in RUN ignored.
REQ-022 SHALL assert exp_ready = FIFO not full OR a pop occurs this cycle, in every state; push+pop when full SHALL both succeed.
REQ-023 SHALL, on start from DONE, flush the FIFO; start from IDLE SHALL keep FIFO contents (preload allowed).
REQ-024 SHALL clear err_count, sample_count, err_chan_mask, underflow, leftover, done, test_passed on any accepted start.
REQ-025 SHALL accept act_valid only in RUN while issued count < NUM_SAMPLES; other act_valid SHALL be ignored with no FIFO pop.
REQ-026 SHALL on accepted act pop FIFO head and register act/exp pair (stage 1); compare and counter update at next edge (latency 1 cycle to counters).
REQ-027 SHALL flag channel k mismatch when |act_k - exp_k| > TOLERANCE, difference computed in DATA_WIDTH+1 bits, no overflow.
REQ-028 SHALL increment err_count by 1 per sample with >=1 mismatching channel, saturating at 16'hFFFF; OR channel flags into err_chan_mask.
REQ-029 SHALL, on accepted act with FIFO empty, set underflow, treat all channels mismatching, no pop.
REQ-030 SHALL, on entering DONE, set leftover if FIFO count (after that edge) is non-zero.
REQ-031 SHALL drive done high throughout DONE; test_passed high in DONE only if err_count=0, underflow=0, leftover=0.

Reset
REQ-032 SHALL, with rst_n low at a rising edge, enter IDLE, empty FIFO, clear all counters/flags; all outputs 0 except exp_ready=1 the cycle after.
REQ-033 SHALL discard in-flight stage-1 pair when reset occurs mid-run; no counter update follows reset.

Structure
REQ-034 SHALL place FSM state enum and parameter defaults in package tb_checker_pkg.
REQ-035 SHALL instantiate one sub-module tb_sync_fifo (parametrised width/depth, sync active-low reset, flush input).

Verification
REQ-036 Defaults, preload 4 vectors, start, 4 matching act, NUM_SAMPLES=4 -> done=1, test_passed=1, err_count=0, sample_count=4.
REQ-037 TOLERANCE=2, exp ch1=100, act ch1=103, others equal -> err_count=1, err_chan_mask=4'b0010, test_passed=0.
REQ-038 Act with FIFO empty in RUN -> underflow=1, err_count=1, err_chan_mask=4'b1111.
REQ-039 NUM_SAMPLES=2, preload 3 -> after 2 acts done=1, leftover=1, test_passed=0; start flushes FIFO, flags clear.
REQ-040 FIFO full (16), push+act same cycle -> both accepted, count stays 16; rst_n low mid-run -> IDLE, counters 0, exp_ready=1.

Source files
------------

// File: rtl/tb_checker_pkg.sv
// Shared types and parameter defaults for the sample checker.
//   checker_state_e : run-control FSM states
//   Def*            : default values for the checker's parameters
//   sat_inc16       : 16-bit increment that sticks at all-ones
package tb_checker_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefChannels   = 4;
  localparam int unsigned DefDepth      = 16;
  localparam int unsigned DefTolerance  = 0;
  localparam int unsigned DefNumSamples = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } checker_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Synchronous FIFO with flush, used to hold expected sample vectors.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset, empties the FIFO
//   flush_i  : discard contents; a push in the same cycle is kept
//   push_i   : write wdata_i (accepted when not full, or when popping)
//   wdata_i  : write data
//   pop_i    : remove head entry (ignored when empty)
//   rdata_o  : head entry
//   full_o   : Depth entries held
//   empty_o  : no entries held
//   count_o  : number of entries held
module tb_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop frees a slot in the same cycle, so push into a full FIFO succeeds then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= PtrW'(do_push);
      count_q <= CntW'(do_push);
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) begin
      mem_q[flush_i ? '0 : wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tb_sample_checker.sv
// Compares a stream of DUT output vectors against queued expected vectors.
// Ports:
//   clk, rst_n         : clock and synchronous active-low reset
//   start              : pulse starting a run (ignored while running)
//   exp_valid/ready    : expected-vector push handshake into the FIFO
//   exp_data           : expected vector, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   act_valid/act_data : DUT output vector, no backpressure
//   done, test_passed  : run finished / finished clean
//   err_count          : mismatching samples, saturating
//   sample_count       : samples compared this run
//   err_chan_mask      : sticky per-channel mismatch flags
//   underflow          : sticky, actual arrived with FIFO empty
//   leftover           : sticky, FIFO non-empty when the run ended
module tb_sample_checker
  import tb_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned CHANNELS    = DefChannels,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned TOLERANCE   = DefTolerance,
  parameter int unsigned NUM_SAMPLES = DefNumSamples
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 exp_valid,
  output logic                                 exp_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       exp_data,
  input  logic                                 act_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       act_data,
  output logic                                 done,
  output logic                                 test_passed,
  output logic [15:0]                          err_count,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]     sample_count,
  output logic [CHANNELS-1:0]                  err_chan_mask,
  output logic                                 underflow,
  output logic                                 leftover
);

  localparam int unsigned VecW    = CHANNELS * DATA_WIDTH;
  localparam int unsigned SampleW = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam logic [SampleW-1:0] NumSamples = SampleW'(NUM_SAMPLES);

  checker_state_e     state_q, state_d;
  logic [SampleW-1:0] issued_q, issued_d;
  logic [SampleW-1:0] sample_q, sample_d;
  logic [15:0]        err_q, err_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic               uflow_q, uflow_d;
  logic               left_q, left_d;
  logic               done_q, done_d;
  logic               passed_q, passed_d;

  // Stage 1: accepted actual plus the expected vector popped alongside it.
  logic               s1_valid_q, s1_uflow_q;
  logic [VecW-1:0]    s1_act_q, s1_exp_q;

  logic               act_accept;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic [VecW-1:0]    fifo_rdata;
  logic [CntW-1:0]    fifo_count, fifo_count_next;
  logic [CHANNELS-1:0] chan_mism;
  logic               entering_done;

  assign act_accept      = (state_q == StRun) && act_valid && (issued_q < NumSamples);
  assign fifo_pop        = act_accept && !fifo_empty;
  assign exp_ready       = !fifo_full || fifo_pop;
  assign fifo_push       = exp_valid && exp_ready;
  assign fifo_flush      = start && (state_q == StDone);
  assign fifo_count_next = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);

  tb_sync_fifo #(
    .Width (VecW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (exp_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sign-extend by one bit so the difference of any two samples cannot overflow.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [DATA_WIDTH-1:0]   a, e;
    logic signed [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0]     mag;
    assign a    = s1_act_q[k*DATA_WIDTH +: DATA_WIDTH];
    assign e    = s1_exp_q[k*DATA_WIDTH +: DATA_WIDTH];
    assign diff = $signed({a[DATA_WIDTH-1], a}) - $signed({e[DATA_WIDTH-1], e});
    assign mag  = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign chan_mism[k] = s1_uflow_q || (64'(mag) > 64'(TOLERANCE));
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q + SampleW'(act_accept);
    sample_d = sample_q;
    err_d    = err_q;
    mask_d   = mask_q;
    uflow_d  = uflow_q;
    left_d   = left_q;

    if (s1_valid_q) begin
      sample_d = sample_q + SampleW'(1);
      if (|chan_mism) begin
        err_d  = sat_inc16(err_q);
        mask_d = mask_q | chan_mism;
      end
      uflow_d = uflow_q | s1_uflow_q;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          issued_d = '0;
          sample_d = '0;
          err_d    = '0;
          mask_d   = '0;
          uflow_d  = 1'b0;
          left_d   = 1'b0;
        end
      end
      StRun: begin
        if (s1_valid_q && (sample_d == NumSamples)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    entering_done = (state_q == StRun) && (state_d == StDone);
    if (entering_done && (fifo_count_next != '0)) left_d = 1'b1;

    done_d   = (state_d == StDone);
    passed_d = done_d && (err_d == '0) && !uflow_d && !left_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      issued_q   <= '0;
      sample_q   <= '0;
      err_q      <= '0;
      mask_q     <= '0;
      uflow_q    <= 1'b0;
      left_q     <= 1'b0;
      done_q     <= 1'b0;
      passed_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_uflow_q <= 1'b0;
      s1_act_q   <= '0;
      s1_exp_q   <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      sample_q   <= sample_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
      uflow_q    <= uflow_d;
      left_q     <= left_d;
      done_q     <= done_d;
      passed_q   <= passed_d;
      s1_valid_q <= act_accept;
      s1_uflow_q <= act_accept && fifo_empty;
      s1_act_q   <= act_data;
      s1_exp_q   <= fifo_rdata;
    end
  end

  assign done          = done_q;
  assign test_passed   = passed_q;
  assign err_count     = err_q;
  assign sample_count  = sample_q;
  assign err_chan_mask = mask_q;
  assign underflow     = uflow_q;
  assign leftover      = left_q;

endmodule

// File: tb/tb_tb_sample_checker.sv
module tb_tb_sample_checker;

  localparam int unsigned DW  = 16;
  localparam int unsigned CH  = 4;
  localparam int unsigned DEP = 16;
  localparam int unsigned TOL = 2;
  localparam int unsigned NS  = 4;
  localparam int unsigned SCW = $clog2(NS + 1);

  typedef logic [CH*DW-1:0] vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           exp_valid = 1'b0;
  logic           exp_ready;
  vec_t           exp_data = '0;
  logic           act_valid = 1'b0;
  vec_t           act_data = '0;
  logic           done, test_passed, underflow, leftover;
  logic [15:0]    err_count;
  logic [SCW-1:0] sample_count;
  logic [CH-1:0]  err_chan_mask;

  always #5 clk = ~clk;

  tb_sample_checker #(
    .DATA_WIDTH  (DW),
    .CHANNELS    (CH),
    .DEPTH       (DEP),
    .TOLERANCE   (TOL),
    .NUM_SAMPLES (NS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .exp_valid     (exp_valid),
    .exp_ready     (exp_ready),
    .exp_data      (exp_data),
    .act_valid     (act_valid),
    .act_data      (act_data),
    .done          (done),
    .test_passed   (test_passed),
    .err_count     (err_count),
    .sample_count  (sample_count),
    .err_chan_mask (err_chan_mask),
    .underflow     (underflow),
    .leftover      (leftover)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected-vector queue plus run bookkeeping.
  vec_t          mq[$];
  int            m_phase;   // 0 idle, 1 running, 2 finished
  int            m_issued, m_samples, m_err;
  logic [CH-1:0] m_mask, pend_mask;
  bit            m_uflow, m_left, pend, pend_uf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CH-1:0] mism(input vec_t a, input vec_t e);
    logic [CH-1:0] r;
    logic signed [DW-1:0] sa, se;
    int d;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      sa = a[k*DW +: DW];
      se = e[k*DW +: DW];
      d  = int'(sa) - int'(se);
      if (d < 0) d = -d;
      r[k] = (d > int'(TOL));
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int sel;
    for (int k = 0; k < CH; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      v[k*DW +: DW] = 16'h8000;
      else if (sel == 1) v[k*DW +: DW] = 16'h7FFF;
      else               v[k*DW +: DW] = 16'($urandom);
    end
    return v;
  endfunction

  // Head of the model queue perturbed a little, sometimes beyond tolerance.
  function automatic vec_t near_head();
    vec_t v;
    int off;
    if (mq.size() == 0) return rand_vec();
    v = mq[0];
    for (int k = 0; k < CH; k++) begin
      off = int'($urandom_range(0, 8)) - 4;
      v[k*DW +: DW] = v[k*DW +: DW] + 16'(off);
    end
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_issued = 0; m_samples = 0; m_err = 0;
    m_mask = '0; m_uflow = 0; m_left = 0; pend = 0; pend_uf = 0; pend_mask = '0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ":done"},          done,          64'(m_phase == 2));
    chk({ctx, ":test_passed"},   test_passed,
        64'(m_phase == 2 && m_err == 0 && !m_uflow && !m_left));
    chk({ctx, ":err_count"},     err_count,     64'(m_err));
    chk({ctx, ":sample_count"},  sample_count,  64'(m_samples));
    chk({ctx, ":err_chan_mask"}, err_chan_mask, 64'(m_mask));
    chk({ctx, ":underflow"},     underflow,     64'(m_uflow));
    chk({ctx, ":leftover"},      leftover,      64'(m_left));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset:exp_ready", exp_ready, 64'(1));
    check_outputs("reset");
  endtask

  task automatic cycle(input bit pv, input vec_t pd, input bit av, input vec_t ad, input bit st);
    bit accept, pop, push, st_acc, cmp, was_run;
    logic [CH-1:0] new_mask;
    @(negedge clk);
    exp_valid = pv; exp_data = pd; act_valid = av; act_data = ad; start = st;
    #1;
    accept  = (m_phase == 1) && av && (m_issued < int'(NS));
    pop     = accept && (mq.size() != 0);
    push    = pv && ((mq.size() < int'(DEP)) || pop);
    st_acc  = st && (m_phase != 1);
    chk("exp_ready", exp_ready, 64'((mq.size() < int'(DEP)) || pop));
    new_mask = '1;
    if (pop) new_mask = mism(ad, mq[0]);
    @(posedge clk);
    was_run = (m_phase == 1);
    cmp = pend;
    if (pend) begin
      m_samples++;
      if (pend_mask != '0) begin
        if (m_err != 65535) m_err++;
        m_mask |= pend_mask;
      end
      if (pend_uf) m_uflow = 1;
    end
    if (st_acc && m_phase == 2) mq.delete();
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(pd);
    pend      = accept;
    pend_uf   = accept && !pop;
    pend_mask = new_mask;
    if (accept) m_issued++;
    if (was_run && cmp && m_samples == int'(NS)) begin
      m_phase = 2;
      m_left  = (mq.size() != 0);
    end
    if (st_acc) begin
      m_phase = 1; m_issued = 0; m_samples = 0; m_err = 0;
      m_mask = '0; m_uflow = 0; m_left = 0;
    end
    #1;
    check_outputs("cycle");
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    vec_t pre[5];
    vec_t v, a;

    model_reset();
    do_reset();

    // Preload four in idle, start, four exact matches.
    for (int i = 0; i < 4; i++) begin
      pre[i] = rand_vec();
      cycle(1'b1, pre[i], 1'b0, '0, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, pre[i], 1'b0);
    idle();
    chk("clean:done", done, 64'(1));
    chk("clean:test_passed", test_passed, 64'(1));
    chk("clean:err_count", err_count, 64'(0));
    chk("clean:sample_count", sample_count, 64'(4));

    // Channel 1 off by 3 with tolerance 2.
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pre[i] = rand_vec();
      if (i == 0) pre[i][1*DW +: DW] = 16'd100;
      cycle(1'b1, pre[i], 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      a = pre[i];
      if (i == 0) a[1*DW +: DW] = 16'd103;
      cycle(1'b0, '0, 1'b1, a, 1'b0);
    end
    idle();
    chk("tol:err_count", err_count, 64'(1));
    chk("tol:err_chan_mask", err_chan_mask, 64'(4'b0010));
    chk("tol:test_passed", test_passed, 64'(0));

    // Actual with an empty FIFO.
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1, rand_vec(), 1'b0);
    for (int i = 0; i < 3; i++) begin
      pre[i] = rand_vec();
      cycle(1'b1, pre[i], 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, pre[i], 1'b0);
    idle();
    chk("uflow:underflow", underflow, 64'(1));
    chk("uflow:err_count", err_count, 64'(1));
    chk("uflow:err_chan_mask", err_chan_mask, 64'(4'b1111));

    // One more expected vector than the run consumes.
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      pre[i] = rand_vec();
      cycle(1'b1, pre[i], 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, pre[i], 1'b0);
    idle();
    chk("left:done", done, 64'(1));
    chk("left:leftover", leftover, 64'(1));
    chk("left:test_passed", test_passed, 64'(0));
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("left:flags_clear", {leftover, done, underflow}, 64'(0));
    for (int i = 0; i < 4; i++) begin
      pre[i] = rand_vec();
      cycle(1'b1, pre[i], 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, pre[i], 1'b0);
    idle();
    chk("flushed:test_passed", test_passed, 64'(1));

    // Full FIFO: push alone refused, push with act accepted, then reset mid-run.
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < int'(DEP); i++) cycle(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    cycle(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    v = rand_vec();
    a = near_head();
    cycle(1'b1, v, 1'b1, a, 1'b0);
    cycle(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    chk("full:count16", 64'(mq.size()), 64'(DEP));
    cycle(1'b0, '0, 1'b1, near_head(), 1'b0);
    do_reset();
    idle();
    chk("rst:sample_count", sample_count, 64'(0));
    chk("rst:exp_ready", exp_ready, 64'(1));

    // Randomised runs.
    for (int r = 0; r < 24; r++) begin
      if (r == 12) do_reset();
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) cycle(1'b1, rand_vec(), 1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
      for (int c = 0; c < 40 && m_phase != 2; c++) begin
        if (r == 20 && c == 5) do_reset();
        if ($urandom_range(0, 7) == 0) a = rand_vec();
        else a = near_head();
        cycle(1'b1 & ($urandom_range(0, 1) == 1), rand_vec(),
              ($urandom_range(0, 2) == 0), a, ($urandom_range(0, 15) == 0));
      end
      idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
